// File: rtl/lb_dispatch.sv
// Four-lane load-balancing dispatcher: each accepted job goes to the enabled worker
// with the fewest outstanding jobs and is presented on a registered output stage.
module lb_dispatch #(
  parameter int W       = 12,
  parameter int DW      = 32,
  parameter int MAX_OUT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [3:0]      en,
  input  logic [3:0]      done,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      out_id,
  output logic [4*W-1:0]  occ,
  output logic            err
);

  localparam logic [W-1:0] MAX_CNT = W'(MAX_OUT);

  // Handshake: a transfer happens on a cycle where valid & ready are both 1; valid
  // never waits on ready, and out_data/out_id hold while out_valid & ~out_ready.

  logic [W-1:0]  cnt_q [4];
  logic [W-1:0]  cnt_d [4];
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [1:0]    out_id_q, out_id_d;
  logic          err_q, err_d;

  logic [3:0]    elig;
  logic [W:0]    key [4];
  logic [W:0]    key_hi, key_lo;
  logic [1:0]    sel_hi, sel_lo, sel;
  logic          any_elig, accept;

  // Key is {ineligible, count}: any eligible worker compares below every ineligible one.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      elig[k] = en[k] && (cnt_q[k] < MAX_CNT);
      key[k]  = elig[k] ? {1'b0, cnt_q[k]} : {1'b1, {W{1'b1}}};
    end
  end

  // Strict less-than at every node, so ties go to the lower index.
  always_comb begin
    sel_hi = (key[3] < key[2]) ? 2'd3 : 2'd2;
    key_hi = (key[3] < key[2]) ? key[3] : key[2];
    sel_lo = (key[1] < key[0]) ? 2'd1 : 2'd0;
    key_lo = (key[1] < key[0]) ? key[1] : key[0];
    sel    = (key_hi < key_lo) ? sel_hi : sel_lo;
  end

  assign any_elig = |elig;
  assign in_ready = any_elig & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    err_d       = err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
      out_id_d    = sel;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // Charge at dispatch, retire on done; a retire against an empty count is an error.
    for (int k = 0; k < 4; k++) begin
      cnt_d[k] = cnt_q[k];
      if (accept && (sel == 2'(k))) begin
        cnt_d[k] = cnt_d[k] + W'(1);
      end
      if (done[k]) begin
        if (cnt_q[k] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[k] = cnt_d[k] - W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      err_q       <= 1'b0;
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      err_q       <= err_d;
      for (int k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_occ
    assign occ[g*W +: W] = cnt_q[g];
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lb_dispatch.sv
// Bench for lb_dispatch: two instances (MAX_OUT 8 and 2) share stimulus and are
// compared against a least-loaded-worker reference model.
module tb_lb_dispatch;
  localparam int W  = 12;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [3:0] en, done;
  logic [1:0] ir, ov, err;
  logic [1:0][DW-1:0] od;
  logic [1:0][1:0] oid;
  logic [1:0][4*W-1:0] occ;

  always #5 clk = ~clk;

  lb_dispatch #(.W(W), .DW(DW), .MAX_OUT(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .en(en), .done(done), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .out_id(oid[0]), .occ(occ[0]), .err(err[0])
  );

  lb_dispatch #(.W(W), .DW(DW), .MAX_OUT(2)) dut_m2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .en(en), .done(done), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .out_id(oid[1]), .occ(occ[1]), .err(err[1])
  );

  // Reference model state, one set per instance.
  int m_max [2] = '{8, 2};
  int m_cnt [2][4];
  bit m_ov [2];
  logic [DW-1:0] m_od [2];
  int m_oid [2];
  bit m_err [2];
  bit m_rdy [2];
  bit m_acc [2];
  logic d_rdy [2];

  int n_vec = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];

  // Pick the least-loaded eligible worker, lowest index on ties.
  task automatic model_step(input int i);
    int best;
    best = -1;
    for (int k = 0; k < 4; k++) begin
      if (en[k] && m_cnt[i][k] < m_max[i]) begin
        if (best < 0 || m_cnt[i][k] < m_cnt[i][best]) best = k;
      end
    end
    m_rdy[i] = (best >= 0) && (!m_ov[i] || out_ready);
    m_acc[i] = in_valid && m_rdy[i] && !rst;
    if (rst) begin
      for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
      m_ov[i] = 0; m_od[i] = '0; m_oid[i] = 0; m_err[i] = 0;
      return;
    end
    for (int k = 0; k < 4; k++) begin
      int old;
      old = m_cnt[i][k];
      if (m_acc[i] && best == k) m_cnt[i][k] = m_cnt[i][k] + 1;
      if (done[k]) begin
        if (old == 0) m_err[i] = 1;
        else m_cnt[i][k] = m_cnt[i][k] - 1;
      end
    end
    if (m_acc[i]) begin
      m_ov[i] = 1; m_od[i] = in_data; m_oid[i] = best;
    end else if (out_ready) begin
      m_ov[i] = 0;
    end
  endtask

  // One clock: sample the combinational ready at the falling edge, advance the model,
  // and return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    d_rdy[0] = ir[0];
    d_rdy[1] = ir[1];
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1; in_valid = 0; done = 0; en = 0; out_ready = 1; in_data = '0;
    tick(); tick();
    rst = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1; done = 4'hF; en = 4'h0; in_valid = 1; out_ready = 1; in_data = 32'h55;
    tick(); tick();
    rst = 0; done = 0; in_valid = 0;
    tick();
    for (int i = 0; i < 2; i++) begin
      n_vec++; if (ov[i] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid[%0d]: got %0b exp 0", i, ov[i]); end
      n_vec++; if (od[i] !== '0) begin n_bad++; $display("FAIL reset_out_data[%0d]: got %0h exp 0", i, od[i]); end
      n_vec++; if (oid[i] !== 2'd0) begin n_bad++; $display("FAIL reset_out_id[%0d]: got %0d exp 0", i, oid[i]); end
      n_vec++; if (occ[i] !== '0) begin n_bad++; $display("FAIL reset_occ[%0d]: got %0h exp 0", i, occ[i]); end
      n_vec++; if (err[i] !== 1'b0) begin n_bad++; $display("FAIL reset_err[%0d]: got %0b exp 0", i, err[i]); end
      n_vec++; if (d_rdy[i] !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready[%0d]: got %0b exp 0", i, d_rdy[i]); end
    end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    en = 4'hF; out_ready = 1; in_valid = 1;
    for (int j = 0; j < 4; j++) begin
      in_data = 32'hA0 + 32'(j);
      tick();
      n_vec++; if (d_rdy[0] !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready: got %0b exp 1", d_rdy[0]); end
      n_vec++; if (ov[0] !== 1'b1) begin n_bad++; $display("FAIL b2b_out_valid: got %0b exp 1", ov[0]); end
      n_vec++; if (od[0] !== 32'hA0 + 32'(j)) begin n_bad++; $display("FAIL b2b_out_data: got %0h exp %0h", od[0], 32'hA0 + 32'(j)); end
      n_vec++; if (oid[0] !== 2'(j)) begin n_bad++; $display("FAIL b2b_out_id: got %0d exp %0d", oid[0], j); end
    end
    in_valid = 0;
    tick();
    n_vec++; if (ov[0] !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %0b exp 0", ov[0]); end
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (occ[0][k*W +: W] !== W'(1)) begin n_bad++; $display("FAIL b2b_occ[%0d]: got %0d exp 1", k, occ[0][k*W +: W]); end
    end
  endtask

  task automatic test_tie();
    logic [3:0] seq [7];
    seq = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h4, 4'h8, 4'h8};
    reset_dut();
    out_ready = 1; in_valid = 1;
    for (int j = 0; j < 7; j++) begin
      en = seq[j]; in_data = 32'hD0 + 32'(j);
      tick();
    end
    en = 4'hF; in_data = 32'hDD;
    tick();
    n_vec++; if (oid[0] !== 2'd1) begin n_bad++; $display("FAIL tie_out_id: got %0d exp 1", oid[0]); end
    n_vec++; if (occ[0][1*W +: W] !== W'(2)) begin n_bad++; $display("FAIL tie_occ1: got %0d exp 2", occ[0][1*W +: W]); end
    n_vec++; if (occ[0][0*W +: W] !== W'(3)) begin n_bad++; $display("FAIL tie_occ0: got %0d exp 3", occ[0][0*W +: W]); end
    in_valid = 0;
    tick();
  endtask

  task automatic test_max_out();
    reset_dut();
    en = 4'b0001; out_ready = 1; in_valid = 1;
    in_data = 32'hB0; tick();
    n_vec++; if (d_rdy[1] !== 1'b1) begin n_bad++; $display("FAIL max_first_ready: got %0b exp 1", d_rdy[1]); end
    n_vec++; if (oid[1] !== 2'd0) begin n_bad++; $display("FAIL max_first_id: got %0d exp 0", oid[1]); end
    in_data = 32'hB1; tick();
    n_vec++; if (occ[1][0 +: W] !== W'(2)) begin n_bad++; $display("FAIL max_occ_full: got %0d exp 2", occ[1][0 +: W]); end
    in_data = 32'hB2; tick();
    n_vec++; if (d_rdy[1] !== 1'b0) begin n_bad++; $display("FAIL max_blocked: got %0b exp 0", d_rdy[1]); end
    n_vec++; if (ov[1] !== 1'b0) begin n_bad++; $display("FAIL max_out_cleared: got %0b exp 0", ov[1]); end
    done = 4'b0001; tick();
    n_vec++; if (occ[1][0 +: W] !== W'(1)) begin n_bad++; $display("FAIL max_retire: got %0d exp 1", occ[1][0 +: W]); end
    done = 4'b0000; tick();
    n_vec++; if (d_rdy[1] !== 1'b1) begin n_bad++; $display("FAIL max_reopen: got %0b exp 1", d_rdy[1]); end
    n_vec++; if (od[1] !== 32'hB2) begin n_bad++; $display("FAIL max_third_data: got %0h exp b2", od[1]); end
    n_vec++; if (oid[1] !== 2'd0) begin n_bad++; $display("FAIL max_third_id: got %0d exp 0", oid[1]); end
    in_valid = 0; tick();
  endtask

  task automatic test_stall();
    reset_dut();
    en = 4'hF; out_ready = 0; in_valid = 1; in_data = 32'hC0;
    tick();
    n_vec++; if (od[0] !== 32'hC0) begin n_bad++; $display("FAIL stall_load: got %0h exp c0", od[0]); end
    in_data = 32'hC1;
    repeat (5) begin
      tick();
      n_vec++; if (d_rdy[0] !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready: got %0b exp 0", d_rdy[0]); end
      n_vec++; if (ov[0] !== 1'b1) begin n_bad++; $display("FAIL stall_valid: got %0b exp 1", ov[0]); end
      n_vec++; if (od[0] !== 32'hC0) begin n_bad++; $display("FAIL stall_data: got %0h exp c0", od[0]); end
      n_vec++; if (oid[0] !== 2'd0) begin n_bad++; $display("FAIL stall_id: got %0d exp 0", oid[0]); end
    end
    out_ready = 1;
    tick();
    n_vec++; if (d_rdy[0] !== 1'b1) begin n_bad++; $display("FAIL release_ready: got %0b exp 1", d_rdy[0]); end
    n_vec++; if (od[0] !== 32'hC1) begin n_bad++; $display("FAIL release_data: got %0h exp c1", od[0]); end
    n_vec++; if (oid[0] !== 2'd1) begin n_bad++; $display("FAIL release_id: got %0d exp 1", oid[0]); end
    in_valid = 0; tick();
  endtask

  task automatic test_done_collide();
    reset_dut();
    out_ready = 1; en = 4'b0100; in_valid = 1; in_data = 32'hE0;
    tick();
    in_data = 32'hE1; done = 4'b0100;
    tick();
    n_vec++; if (oid[0] !== 2'd2) begin n_bad++; $display("FAIL collide_id: got %0d exp 2", oid[0]); end
    n_vec++; if (occ[0][2*W +: W] !== W'(1)) begin n_bad++; $display("FAIL collide_occ2: got %0d exp 1", occ[0][2*W +: W]); end
    n_vec++; if (err[0] !== 1'b0) begin n_bad++; $display("FAIL collide_err: got %0b exp 0", err[0]); end
    in_valid = 0; done = 4'b1000;
    tick();
    n_vec++; if (err[0] !== 1'b1) begin n_bad++; $display("FAIL underflow_err: got %0b exp 1", err[0]); end
    n_vec++; if (occ[0][3*W +: W] !== W'(0)) begin n_bad++; $display("FAIL underflow_occ3: got %0d exp 0", occ[0][3*W +: W]); end
    done = 4'b0000;
    tick();
    n_vec++; if (err[0] !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %0b exp 1", err[0]); end
    en = 4'b0001; in_valid = 1; in_data = 32'hE2; done = 4'b0001;
    tick();
    n_vec++; if (occ[0][0 +: W] !== W'(1)) begin n_bad++; $display("FAIL zero_dispatch_done: got %0d exp 1", occ[0][0 +: W]); end
    in_valid = 0; done = 0; tick();
  endtask

  task automatic test_mid_reset();
    reset_dut();
    en = 4'hF; out_ready = 1; in_valid = 1;
    for (int j = 0; j < 6; j++) begin
      in_data = 32'hF0 + 32'(j);
      tick();
    end
    n_vec++; if (occ[0] !== {W'(1), W'(1), W'(2), W'(2)}) begin n_bad++; $display("FAIL pre_reset_occ: got %0h exp 2,2,1,1", occ[0]); end
    n_vec++; if (ov[0] !== 1'b1) begin n_bad++; $display("FAIL pre_reset_valid: got %0b exp 1", ov[0]); end
    rst = 1; done = 4'hF; in_valid = 0;
    tick();
    n_vec++; if (ov[0] !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %0b exp 0", ov[0]); end
    n_vec++; if (occ[0] !== '0) begin n_bad++; $display("FAIL mid_rst_occ: got %0h exp 0", occ[0]); end
    n_vec++; if (err[0] !== 1'b0) begin n_bad++; $display("FAIL mid_rst_err: got %0b exp 0", err[0]); end
    rst = 0; done = 0;
    tick();
    n_vec++; if (err[0] !== 1'b0) begin n_bad++; $display("FAIL post_rst_err: got %0b exp 0", err[0]); end
  endtask

  task automatic test_random();
    logic [DW-1:0] e;
    logic [4*W-1:0] e_occ;
    reset_dut();
    repeat (600) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      en        = 4'($urandom_range(0, 15));
      done      = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      if (!rst && ov[0] && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL sb_unexpected: got %0h exp none", od[0]);
        end else begin
          e = exp_q.pop_front();
          if (od[0] !== e) begin n_bad++; $display("FAIL sb_data: got %0h exp %0h", od[0], e); end
        end
      end
      tick();
      if (rst) exp_q.delete();
      else if (m_acc[0]) exp_q.push_back(in_data);
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < 4; k++) e_occ[k*W +: W] = W'(m_cnt[i][k]);
        n_vec++; if (d_rdy[i] !== m_rdy[i]) begin n_bad++; $display("FAIL rnd_in_ready[%0d]: got %0b exp %0b", i, d_rdy[i], m_rdy[i]); end
        n_vec++; if (ov[i] !== m_ov[i]) begin n_bad++; $display("FAIL rnd_out_valid[%0d]: got %0b exp %0b", i, ov[i], m_ov[i]); end
        n_vec++; if (occ[i] !== e_occ) begin n_bad++; $display("FAIL rnd_occ[%0d]: got %0h exp %0h", i, occ[i], e_occ); end
        n_vec++; if (err[i] !== m_err[i]) begin n_bad++; $display("FAIL rnd_err[%0d]: got %0b exp %0b", i, err[i], m_err[i]); end
        if (m_ov[i]) begin
          n_vec++; if (od[i] !== m_od[i]) begin n_bad++; $display("FAIL rnd_out_data[%0d]: got %0h exp %0h", i, od[i], m_od[i]); end
          n_vec++; if (oid[i] !== 2'(m_oid[i])) begin n_bad++; $display("FAIL rnd_out_id[%0d]: got %0d exp %0d", i, oid[i], m_oid[i]); end
        end
      end
    end
    rst = 0; in_valid = 0; done = 0;
  endtask

  initial begin
    rst = 1; in_valid = 0; in_data = '0; en = 4'h0; done = 4'h0; out_ready = 1;
    test_reset();
    test_back_to_back();
    test_tie();
    test_max_out();
    test_stall();
    test_done_collide();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lb_dispatch.md
Name: lb_dispatch

Overview:
- Load-balancing dispatcher for four worker lanes.
- Accepts jobs on a valid/ready input and assigns each one to the eligible worker with the fewest outstanding jobs.
- Presents each job on a registered valid/ready output, tagged with a 2-bit worker id.
- Keeps per-worker outstanding counters: incremented on dispatch, decremented on the worker's done pulse.
- Acts as the issuing end of the per-id usage/min-id tracking used elsewhere in the design.

Parameters:
- W, 12, width of each per-worker outstanding counter.
- DW, 32, job payload width.
- MAX_OUT, 8, maximum outstanding jobs per worker; 1 <= MAX_OUT <= 2^W-1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  job offered.
- in_ready  output  1  job accepted when in_valid & in_ready.
- in_data  input  DW  job payload.
- en  input  4  per-worker enable; a worker with en[k]=0 is never selected.
- done  input  4  done[k]=1 for one cycle retires one job from worker k.
- out_valid  output  1  dispatched job valid.
- out_ready  input  1  downstream accepts when out_valid & out_ready.
- out_data  output  DW  dispatched payload.
- out_id  output  2  worker assigned to out_data.
- occ  output  4*W  outstanding counts, lane k at bits [k*W +: W], registered.
- err  output  1  sticky: done pulse received on a worker whose count is 0.

Behaviour:
- Reset values:
  - all counters 0
  - out_valid=0, out_data=0, out_id=0, err=0
  - in_ready is combinational and therefore 0 while out_valid=0 and every en bit is 0.
- Eligibility: worker k is eligible iff en[k]=1 and cnt[k] < MAX_OUT. any_elig = OR of the four.
- Selection: combinational two-level compare tree over registered counts.
  - Pair (3,2): pick 3 only if cnt3 < cnt2 strictly, else 2.
  - Pair (1,0): pick 1 only if cnt1 < cnt0 strictly, else 0.
  - Final: pick the (3,2) winner only if its count is strictly less than the (1,0) winner's.
  - Ineligible workers enter the tree as count 2^W-1 plus an invalid flag, so an eligible worker always beats an ineligible one.
  - Ties resolve to the lower index.
- in_ready = any_elig & (~out_valid | out_ready). No dependence on in_valid.
- Accept cycle (in_valid & in_ready), effective next edge:
  - out_data <= in_data
  - out_id <= sel
  - out_valid <= 1
  - cnt[sel] increments.
- The count increments at dispatch, not at output handshake. A job held in the output register is already charged to its worker.
- Output register:
  - out_valid clears on an out_valid & out_ready cycle without a new accept.
  - Back-to-back accept with a simultaneous output handshake gives a full-throughput, 1-cycle latency from input accept to out_valid.
  - out_data and out_id are stable while out_valid & ~out_ready.
- Done handling: for each k with done[k]=1 and cnt[k]>0, cnt[k] decrements. Multiple done bits in one cycle are all applied.
- Simultaneous increment and decrement on the same worker: count unchanged.
- done[k] with cnt[k]=0:
  - count stays 0, no wrap
  - err <= 1, held until rst.
  - This applies even if the same cycle dispatches to k: the net count becomes 1 and err is still set.
- Counters never exceed MAX_OUT, enforced by eligibility. No wrap-around is possible.
- en changes take effect combinationally in the same cycle's selection. Disabling a worker does not alter its count or the held output.
- Selection uses pre-update counts. A done pulse in the current cycle does not influence the current cycle's selection.
- rst asserted mid-operation:
  - the held output job is discarded
  - all counts clear, regardless of jobs in flight at workers
  - done pulses during rst are ignored and do not set err.

Test Plan:
1. After rst, en=4'hF, out_ready=1, four jobs 0xA0..0xA3 back-to-back -> out_id sequence 0,1,2,3 on consecutive cycles; occ = 1,1,1,1; in_ready held 1.
2. Counts (0..3)=3,1,1,2, en=4'hF -> next job gets out_id=1 (tie 1 vs 2 resolves low); occ lane 1 becomes 2.
3. MAX_OUT=2, en=4'b0001, out_ready=1, three jobs offered -> first two dispatched to id 0, then in_ready=0. Pulse done[0] -> in_ready=1 next cycle and the third job dispatches to id 0.
4. out_ready=0 with a job held -> in_ready=0 and out_data/out_id stable for 5 cycles. Raise out_ready with in_valid=1 -> the held job retires and the new job loads in the same edge.
5. cnt[2]=1, same cycle: dispatch selects 2 and done[2]=1 -> occ lane 2 stays 1, err=0. Then done[3] with cnt[3]=0 -> err=1, occ lane 3 stays 0.
6. Mid-stream rst with out_valid=1, occ=2,2,1,1 -> next cycle out_valid=0, occ all 0, err=0. done pulses during rst leave err=0.
